// File: rtl/csr_ctrl_pkg.sv
// csr_ctrl shared definitions: CSR addresses, funct3 encodings
// and sequencer state encodings.
package csr_ctrl_pkg;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    localparam logic [2:0] OP_RW  = 3'b001;
    localparam logic [2:0] OP_RS  = 3'b010;
    localparam logic [2:0] OP_RC  = 3'b011;
    localparam logic [2:0] OP_RWI = 3'b101;
    localparam logic [2:0] OP_RSI = 3'b110;
    localparam logic [2:0] OP_RCI = 3'b111;

    localparam logic [1:0] K_NONE = 2'b00;
    localparam logic [1:0] K_WR   = 2'b01;
    localparam logic [1:0] K_SET  = 2'b10;
    localparam logic [1:0] K_CLR  = 2'b11;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_CSR_RD     = 3'd1;
    localparam logic [2:0] S_CSR_WR     = 3'd2;
    localparam logic [2:0] S_TRAP_EPC   = 3'd3;
    localparam logic [2:0] S_TRAP_CAUSE = 3'd4;
    localparam logic [2:0] S_TRAP_TVEC  = 3'd5;
    localparam logic [2:0] S_MRET_EPC   = 3'd6;
    localparam logic [2:0] S_RESP       = 3'd7;

endpackage

// File: rtl/csr_ctrl_if.sv
// Core-side request/response and CSR-file port bundle
// for the CSR sequencer.
interface csr_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [11:0]     req_addr;
    logic [XLEN-1:0] req_src;
    logic            req_src_x0;
    logic            trap_valid;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_cause;
    logic            mret_valid;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_illegal;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport slave (
        input  req_valid, req_op, req_addr, req_src, req_src_x0,
        input  trap_valid, trap_pc, trap_cause, mret_valid,
        input  csr_rdata,
        output req_ready, csr_we, csr_addr, csr_wdata,
        output resp_valid, resp_rdata, resp_illegal,
        output redirect_valid, redirect_pc
    );

    modport master (
        output req_valid, req_op, req_addr, req_src, req_src_x0,
        output trap_valid, trap_pc, trap_cause, mret_valid,
        output csr_rdata,
        input  req_ready, csr_we, csr_addr, csr_wdata,
        input  resp_valid, resp_rdata, resp_illegal,
        input  redirect_valid, redirect_pc
    );

endinterface

// File: rtl/csr_ctrl_alu.sv
// Read-modify-write combiner: new value, write enable and
// read-only violation for one Zicsr access.
module csr_ctrl_alu
    import csr_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] src,
    input  logic            src_x0,
    input  logic [1:0]      addr_perm,
    output logic [XLEN-1:0] wdata,
    output logic            we,
    output logic            illegal
);

    logic wr_try;
    logic ro;

    // RW always writes; set/clear with x0 is a pure read
    assign wr_try  = (op == K_WR) | ~src_x0;
    assign ro      = (addr_perm == 2'b11);
    assign we      = wr_try & ~ro;
    assign illegal = wr_try & ro;

    always_comb begin
        wdata = '0;
        unique case (op)
            K_WR:    wdata = src;
            K_SET:   wdata = old | src;
            K_CLR:   wdata = old & ~src;
            default: wdata = '0;
        endcase
    end

endmodule

// File: rtl/csr_ctrl.sv
// CSR port sequencer: serialises Zicsr read-modify-write,
// trap entry and mret onto the single CSR-file port.
module csr_ctrl
    import csr_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic         clk,
    input logic         rst_n,
    csr_ctrl_if.slave   bus
);

    localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

    logic [2:0]      state_q, state_d;
    logic [1:0]      kind_q, kind_d;
    logic [11:0]     addr_q, addr_d;
    logic [XLEN-1:0] src_q, src_d;
    logic [XLEN-1:0] old_q, old_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            x0_q, x0_d;
    logic            ill_q, ill_d;
    logic            redir_q, redir_d;

    logic [XLEN-1:0] alu_wdata;
    logic            alu_we;
    logic            alu_ill;

    csr_ctrl_alu #(.XLEN(XLEN)) u_alu (
        .op        (kind_q),
        .old       (old_q),
        .src       (src_q),
        .src_x0    (x0_q),
        .addr_perm (addr_q[11:10]),
        .wdata     (alu_wdata),
        .we        (alu_we),
        .illegal   (alu_ill)
    );

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        src_d   = src_q;
        old_d   = old_q;
        tgt_d   = tgt_q;
        x0_d    = x0_q;
        ill_d   = ill_q;
        redir_d = redir_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.trap_valid) begin
                    // trap operands held in src/old until written out
                    src_d   = bus.trap_pc & ALIGN;
                    old_d   = bus.trap_cause;
                    redir_d = 1'b1;
                    ill_d   = 1'b0;
                    state_d = S_TRAP_EPC;
                end else if (bus.mret_valid) begin
                    old_d   = '0;
                    redir_d = 1'b1;
                    ill_d   = 1'b0;
                    state_d = S_MRET_EPC;
                end else if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    src_d   = bus.req_src;
                    x0_d    = bus.req_src_x0;
                    old_d   = '0;
                    redir_d = 1'b0;
                    ill_d   = 1'b0;
                    state_d = S_CSR_RD;
                    unique case (bus.req_op)
                        OP_RW, OP_RWI: kind_d = K_WR;
                        OP_RS, OP_RSI: kind_d = K_SET;
                        OP_RC, OP_RCI: kind_d = K_CLR;
                        default: begin
                            kind_d  = K_NONE;
                            ill_d   = 1'b1;
                            state_d = S_RESP;
                        end
                    endcase
                end
            end
            S_CSR_RD: begin
                old_d   = bus.csr_rdata;
                state_d = S_CSR_WR;
            end
            S_CSR_WR: begin
                ill_d   = alu_ill;
                state_d = S_RESP;
            end
            S_TRAP_EPC:   state_d = S_TRAP_CAUSE;
            S_TRAP_CAUSE: state_d = S_TRAP_TVEC;
            S_TRAP_TVEC: begin
                tgt_d   = bus.csr_rdata & ALIGN;
                state_d = S_RESP;
            end
            S_MRET_EPC: begin
                tgt_d   = bus.csr_rdata;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            kind_q  <= K_NONE;
            addr_q  <= '0;
            src_q   <= '0;
            old_q   <= '0;
            tgt_q   <= '0;
            x0_q    <= 1'b0;
            ill_q   <= 1'b0;
            redir_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
            old_q   <= old_d;
            tgt_q   <= tgt_d;
            x0_q    <= x0_d;
            ill_q   <= ill_d;
            redir_q <= redir_d;
        end
    end

    always_comb begin
        bus.csr_we    = 1'b0;
        bus.csr_addr  = '0;
        bus.csr_wdata = '0;
        unique case (state_q)
            S_CSR_RD: bus.csr_addr = addr_q;
            S_CSR_WR: begin
                bus.csr_addr  = addr_q;
                bus.csr_wdata = alu_wdata;
                bus.csr_we    = alu_we;
            end
            S_TRAP_EPC: begin
                bus.csr_addr  = CSR_MEPC;
                bus.csr_wdata = src_q;
                bus.csr_we    = 1'b1;
            end
            S_TRAP_CAUSE: begin
                bus.csr_addr  = CSR_MCAUSE;
                bus.csr_wdata = old_q;
                bus.csr_we    = 1'b1;
            end
            S_TRAP_TVEC: bus.csr_addr = CSR_MTVEC;
            S_MRET_EPC:  bus.csr_addr = CSR_MEPC;
            default: ;
        endcase
    end

    logic resp;
    assign resp               = (state_q == S_RESP);
    assign bus.req_ready      = (state_q == S_IDLE);
    assign bus.resp_valid     = resp;
    assign bus.resp_rdata     = (resp && !redir_q) ? old_q : '0;
    assign bus.resp_illegal   = resp & ill_q;
    assign bus.redirect_valid = resp & redir_q;
    assign bus.redirect_pc    = (resp && redir_q) ? tgt_q : '0;

endmodule
